rgb_led_pwm: RTL

RGB_LED_PWM -- requirements
Module: rgb_led_pwm

---
 rtl/rgb_led_pwm_pkg.sv | 29 ++
 rtl/rgb_led_pwm_chan.sv | 87 ++++++++
 rtl/rgb_led_pwm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rgb_led_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module : rgb_led_pwm_pkg
// Brief  : Shared mode encoding and gamma mapping for the RGB LED PWM block.
// Rev    : 1.0
// ============================================================================
package rgb_led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam int c_gamma_w = 12;

    // (d*(d+1)) >> bits keeps 0 -> 0 and all-ones -> all-ones for any width.
    function automatic logic [c_gamma_w-1:0] gamma_map(
        input logic [c_gamma_w-1:0] duty,
        input int unsigned          bits
    );
        logic [2*c_gamma_w:0] sq;
        sq = {{(c_gamma_w+1){1'b0}}, duty} * ({{(c_gamma_w+1){1'b0}}, duty} + 1'b1);
        return c_gamma_w'(sq >> bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_led_pwm_chan.sv
`default_nettype none
// ============================================================================
// Module : rgb_led_pwm_chan
// Brief  : One RGB LED: committed mode/duty registers, compare and output flop.
// Build  : RGB_LED_PWM_GAMMA_EN selects gamma-mapped duty at commit.
// Rev    : 1.0
// ============================================================================
module rgb_led_pwm_chan
    import rgb_led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    i_load,
    input  logic [1:0]              i_mode,
    input  logic [3*PWM_BITS-1:0]   i_rgb,
    input  logic [PWM_BITS-1:0]     i_pwm_cnt,
    input  logic                    i_blink_phase,
    input  logic [PWM_BITS-1:0]     i_env,
    output logic [2:0]              o_led
);

    localparam logic [PWM_BITS:0] c_env_full = {1'b1, {PWM_BITS{1'b0}}};

    mode_e                      mode_q, mode_d;
    logic [2:0][PWM_BITS-1:0]   duty_q, duty_d;
    logic [2:0]                 led_q, led_d;
    logic [PWM_BITS:0]          w_env_sat;
    logic [2:0]                 w_on_steady;
    logic [2:0]                 w_on_breathe;

    // A full-scale envelope must reproduce the duty exactly, so P counts as 2^PWM_BITS.
    assign w_env_sat = (i_env == '1) ? c_env_full : {1'b0, i_env};

    always_comb begin
        mode_d = mode_q;
        duty_d = duty_q;
        if (i_load) begin
            mode_d = mode_e'(i_mode);
            for (int c = 0; c < 3; c++) begin
`ifdef RGB_LED_PWM_GAMMA_EN
                duty_d[c] = PWM_BITS'(gamma_map(c_gamma_w'(i_rgb[c*PWM_BITS +: PWM_BITS]), PWM_BITS));
`else
                duty_d[c] = i_rgb[c*PWM_BITS +: PWM_BITS];
`endif
            end
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_col
        logic [2*PWM_BITS-1:0] w_prod;
        logic [PWM_BITS-1:0]   w_eff;

        assign w_prod          = (2*PWM_BITS)'(duty_q[c]) * (2*PWM_BITS)'(w_env_sat);
        assign w_eff           = PWM_BITS'(w_prod >> PWM_BITS);
        assign w_on_steady[c]  = (i_pwm_cnt < duty_q[c]);
        assign w_on_breathe[c] = (i_pwm_cnt < w_eff);
    end

    always_comb begin
        led_d = 3'b000;
        case (mode_q)
            MODE_OFF:     led_d = 3'b000;
            MODE_STEADY:  led_d = w_on_steady;
            MODE_BLINK:   led_d = w_on_steady & {3{i_blink_phase}};
            MODE_BREATHE: led_d = w_on_breathe;
            default:      led_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mode_q <= MODE_OFF;
            duty_q <= '0;
            led_q  <= 3'b000;
        end else begin
            mode_q <= mode_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign o_led = led_q;

endmodule
`default_nettype wire

// File: rtl/rgb_led_pwm.sv
`default_nettype none
// ============================================================================
// Module : rgb_led_pwm
// Brief  : Multi-LED RGB PWM driver with OFF/STEADY/BLINK/BREATHE modes and a
//          single-entry configuration slot committed at PWM frame boundaries.
// Build  : define RGB_LED_PWM_GAMMA_EN for gamma-mapped duty values.
// Rev    : 1.0
// ============================================================================
module rgb_led_pwm
    import rgb_led_pwm_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int PWM_BITS    = 8,
    parameter int BLINK_HALF  = 25_000_000,
    parameter int BREATHE_DIV = 392,
    localparam int LED_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                    clk_100mhz,
    input  logic                    arst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [LED_W-1:0]        cfg_led,
    input  logic [1:0]              cfg_mode,
    input  logic [3*PWM_BITS-1:0]   cfg_rgb,
    output logic [3*NUM_LEDS-1:0]   led_rgb,
    output logic                    frame_tick
);

    localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int c_div_w   = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

    localparam logic [PWM_BITS-1:0]  c_cnt_last   = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);
    localparam logic [c_div_w-1:0]   c_div_last   = c_div_w'(BREATHE_DIV - 1);

    logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [c_blink_w-1:0]    blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [c_div_w-1:0]      div_cnt_q, div_cnt_d;
    logic [PWM_BITS-1:0]     env_q, env_d;
    logic                    env_rise_q, env_rise_d;
    logic                    pending_q, pending_d;
    logic [LED_W-1:0]        slot_led_q, slot_led_d;
    mode_e                   slot_mode_q, slot_mode_d;
    logic [3*PWM_BITS-1:0]   slot_rgb_q, slot_rgb_d;
    logic                    w_accept;
    logic                    w_commit;

    assign w_accept = cfg_valid & ~pending_q;
    assign w_commit = frame_tick_q & pending_q;

    // Frame of 2^PWM_BITS-1 cycles; the tick flop is aligned with the last count.
    always_comb begin
        pwm_cnt_d     = (pwm_cnt_q == c_cnt_last) ? '0 : pwm_cnt_q + 1'b1;
        frame_tick_d  = (pwm_cnt_d == c_cnt_last);
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Triangle envelope: each extreme is held for one step, then direction flips.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        env_d      = env_q;
        env_rise_d = env_rise_q;
        if (frame_tick_q) begin
            if (div_cnt_q == c_div_last) begin
                div_cnt_d = '0;
                if (env_rise_q) begin
                    if (env_q == '1) begin
                        env_d      = env_q - 1'b1;
                        env_rise_d = 1'b0;
                    end else begin
                        env_d = env_q + 1'b1;
                    end
                end else begin
                    if (env_q == '0) begin
                        env_d      = env_q + 1'b1;
                        env_rise_d = 1'b1;
                    end else begin
                        env_d = env_q - 1'b1;
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        pending_d   = pending_q;
        slot_led_d  = slot_led_q;
        slot_mode_d = slot_mode_q;
        slot_rgb_d  = slot_rgb_q;
        if (w_commit) begin
            pending_d = 1'b0;
        end
        if (w_accept) begin
            pending_d   = 1'b1;
            slot_led_d  = cfg_led;
            slot_mode_d = mode_e'(cfg_mode);
            slot_rgb_d  = cfg_rgb;
        end
    end

    always_ff @(posedge clk_100mhz or negedge arst_n) begin
        if (!arst_n) begin
            pwm_cnt_q     <= '0;
            frame_tick_q  <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            div_cnt_q     <= '0;
            env_q         <= '0;
            env_rise_q    <= 1'b1;
            pending_q     <= 1'b0;
            slot_led_q    <= '0;
            slot_mode_q   <= MODE_OFF;
            slot_rgb_q    <= '0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            frame_tick_q  <= frame_tick_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            div_cnt_q     <= div_cnt_d;
            env_q         <= env_d;
            env_rise_q    <= env_rise_d;
            pending_q     <= pending_d;
            slot_led_q    <= slot_led_d;
            slot_mode_q   <= slot_mode_d;
            slot_rgb_q    <= slot_rgb_d;
        end
    end

    // An out-of-range index matches no channel, so its commit is silently dropped.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        rgb_led_pwm_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk           (clk_100mhz),
            .arst_n        (arst_n),
            .i_load        (w_commit && (slot_led_q == LED_W'(i))),
            .i_mode        (slot_mode_q),
            .i_rgb         (slot_rgb_q),
            .i_pwm_cnt     (pwm_cnt_q),
            .i_blink_phase (blink_phase_q),
            .i_env         (env_q),
            .o_led         (led_rgb[3*i +: 3])
        );
    end

    assign cfg_ready  = ~pending_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
